feature_map_reader: RTL and testbench

FEATURE_MAP_READER -- requirements
Module: feature_map_reader

---
 rtl/feature_map_reader_pkg.sv | 19 +
 rtl/feature_map_reader_rd_data_fifo.sv | 54 +++++
 rtl/feature_map_reader.sv | 145 ++++++++++++++
 tb/tb_feature_map_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_map_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | feature_map_reader_pkg: shared sizes and FSM state type  (rev 1.0)   |
// +----------------------------------------------------------------------+
package feature_map_reader_pkg;

    localparam int K_CHANNELS  = 4;
    localparam int SRAM_ADDR_W = 10;
    localparam int INT_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_rd_state_e;

endpackage
`default_nettype wire

// File: rtl/feature_map_reader_rd_data_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rd_data_fifo: synchronous FIFO, wrap-bit pointers, no output reg     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rd_data_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_async_n_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem[rd_ptr_q[AW-1:0]];

    // Storage carries no reset; emptiness is decided by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/feature_map_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | feature_map_reader: credit-limited SRAM burst reader feeding a       |
// | valid/ready stream through a small return FIFO        (rev 1.0)      |
// +----------------------------------------------------------------------+
module feature_map_reader #(
    parameter int K_CHANNELS  = feature_map_reader_pkg::K_CHANNELS,
    parameter int SRAM_ADDR_W = feature_map_reader_pkg::SRAM_ADDR_W,
    parameter int INT_WIDTH   = feature_map_reader_pkg::INT_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_async_n_i,
    input  logic                                      start_i,
    input  logic [SRAM_ADDR_W-1:0]                    base_addr_i,
    input  logic [SRAM_ADDR_W:0]                      length_i,
    output logic [K_CHANNELS-1:0]                     sram_rd_en_o,
    output logic [K_CHANNELS-1:0][SRAM_ADDR_W-1:0]    sram_rd_addr_o,
    input  logic [K_CHANNELS-1:0][INT_WIDTH-1:0]      sram_rd_data_i,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic [K_CHANNELS-1:0][INT_WIDTH-1:0]      data_o,
    output logic                                      last_o,
    output logic                                      busy_o,
    output logic                                      done_o
);
    import feature_map_reader_pkg::*;

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int DATA_W  = K_CHANNELS * INT_WIDTH;
    localparam int PEND_W  = FIFO_AW + 2;
    localparam logic [SRAM_ADDR_W:0] CNT_ONE = 1;

    fsm_rd_state_e            state_q;
    logic [SRAM_ADDR_W-1:0]   base_q;
    logic [SRAM_ADDR_W-1:0]   rd_addr_q;
    logic [SRAM_ADDR_W:0]     len_q;
    logic [SRAM_ADDR_W:0]     issued_q;
    logic [SRAM_ADDR_W:0]     delivered_q;
    logic                     rd_en_q;
    logic                     rd_ret_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [FIFO_AW:0]         fifo_count;
    logic [DATA_W-1:0]        fifo_head;
    logic [PEND_W-1:0]        pending;
    logic                     can_issue;
    logic                     xfer;
    logic                     final_word;

    // Words already buffered plus the two read stages still in flight.
    assign pending    = PEND_W'(fifo_count) + PEND_W'(rd_en_q) + PEND_W'(rd_ret_q);
    assign can_issue  = !fifo_full && (pending < PEND_W'(FIFO_DEPTH));
    assign valid_o    = !fifo_empty;
    assign xfer       = valid_o && ready_i;
    assign final_word = valid_o && ((delivered_q + CNT_ONE) == len_q);
    assign last_o     = final_word;
    assign data_o     = valid_o ? fifo_head : '0;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    for (genvar g = 0; g < K_CHANNELS; g++) begin : g_lane
        assign sram_rd_en_o[g]   = rd_en_q;
        assign sram_rd_addr_o[g] = rd_addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_ret_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_ret_q <= rd_en_q;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
            if (xfer) begin
                delivered_q <= delivered_q + CNT_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q      <= base_addr_i;
                        len_q       <= length_i;
                        issued_q    <= '0;
                        delivered_q <= '0;
                        busy_q      <= 1'b1;
                        if (length_i == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (can_issue) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= base_q + issued_q[SRAM_ADDR_W-1:0];
                        issued_q  <= issued_q + CNT_ONE;
                        if ((issued_q + CNT_ONE) == len_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer && final_word) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rd_data_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_data_fifo (
        .clk_i         (clk_i),
        .rst_async_n_i (rst_async_n_i),
        .wr_en_i       (rd_ret_q),
        .wr_data_i     (sram_rd_data_i),
        .rd_en_i       (ready_i),
        .rd_data_o     (fifo_head),
        .empty_o       (fifo_empty),
        .full_o        (fifo_full),
        .count_o       (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_feature_map_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_feature_map_reader: randomized bench with queue-based reference   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_feature_map_reader;
    localparam int K     = feature_map_reader_pkg::K_CHANNELS;
    localparam int AW    = feature_map_reader_pkg::SRAM_ADDR_W;
    localparam int IW    = feature_map_reader_pkg::INT_WIDTH;
    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [AW-1:0]            base = '0;
    logic [AW:0]              len = '0;
    logic [K-1:0]             sram_rd_en;
    logic [K-1:0][AW-1:0]     sram_rd_addr;
    logic [K-1:0][IW-1:0]     sram_rd_data = '0;
    logic                     valid;
    logic                     ready = 1'b1;
    logic [K-1:0][IW-1:0]     data;
    logic                     last;
    logic                     busy;
    logic                     done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ready_mode = 0;
    int salt;
    int strobes_total = 0;
    int xfers_total   = 0;
    int last_xfer_cyc = 0;
    int start_cyc     = 0;
    bit stalled = 1'b0;
    bit lanes_same;
    logic [K*IW-1:0] held_data;
    logic [AW-1:0]   exp_addr_q[$];
    logic [K*IW-1:0] exp_word_q[$];

    feature_map_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_async_n_i  (rst_n),
        .start_i        (start),
        .base_addr_i    (base),
        .length_i       (len),
        .sram_rd_en_o   (sram_rd_en),
        .sram_rd_addr_o (sram_rd_addr),
        .sram_rd_data_i (sram_rd_data),
        .valid_o        (valid),
        .ready_i        (ready),
        .data_o         (data),
        .last_o         (last),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [IW-1:0] lane_byte(input logic [AW-1:0] a, input int lane);
        return IW'(int'(a) * 7 + lane * 61 + salt);
    endfunction

    function automatic logic [K*IW-1:0] word_at(input logic [AW-1:0] a);
        logic [K*IW-1:0] w;
        for (int l = 0; l < K; l++) w[l*IW +: IW] = lane_byte(a, l);
        return w;
    endfunction

    // Bank model: data appears exactly one cycle after the strobe.
    always @(posedge clk) begin
        for (int l = 0; l < K; l++)
            if (sram_rd_en[l]) sram_rd_data[l] <= lane_byte(sram_rd_addr[l], l);
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 3 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: strobe addresses, delivered words, last, hold-while-stalled, credit bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr_q.delete();
            exp_word_q.delete();
            strobes_total = 0;
            xfers_total   = 0;
            stalled       = 1'b0;
        end else begin
            if (sram_rd_en != '0) begin
                lanes_same = 1'b1;
                for (int l = 1; l < K; l++) if (sram_rd_addr[l] !== sram_rd_addr[0]) lanes_same = 1'b0;
                check_eq("strobe_all_lanes", sram_rd_en, {K{1'b1}});
                check_eq("addr_lanes_equal", lanes_same, 1);
                check_eq("strobe_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) check_eq("rd_addr", sram_rd_addr[0], exp_addr_q.pop_front());
                strobes_total++;
                check_eq("occupancy_bound", (strobes_total - xfers_total) <= DEPTH, 1);
            end
            if (stalled && valid) check_eq("hold_data", data, held_data);
            if (valid) begin
                check_eq("word_expected", exp_word_q.size() != 0, 1);
                if (exp_word_q.size() != 0) begin
                    check_eq("last", last, exp_word_q.size() == 1);
                    if (ready) check_eq("data", data, exp_word_q.pop_front());
                end
                if (ready) begin
                    xfers_total++;
                    last_xfer_cyc = cyc;
                end
            end
            stalled   = valid && !ready;
            held_data = data;
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
        logic [AW-1:0] a;
        @(negedge clk);
        base  = b;
        len   = l;
        start = 1'b1;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_word_q.push_back(word_at(a));
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(output int done_cyc);
        bit seen = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        check_eq("done_seen", seen, 1);
        if (seen) begin
            check_eq("busy_at_done", busy, 1);
            check_eq("words_left", exp_word_q.size(), 0);
            check_eq("strobes_left", exp_addr_q.size(), 0);
            @(negedge clk);
            check_eq("done_pulse_1cyc", done, 0);
            check_eq("busy_after_done", busy, 0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rd_en"}, sram_rd_en, 0);
        check_eq({tag, "_rd_addr"}, sram_rd_addr, 0);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_data"}, data, 0);
        check_eq({tag, "_last"}, last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        int dc;
        int s0;
        salt = int'($urandom_range(0, 255));
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic burst with latency and throughput.
        ready_mode = 0;
        start_burst(10'h010, 11'd8);
        check_eq("lat_n_strobe", sram_rd_en, 0);
        check_eq("busy_after_start", busy, 1);
        @(posedge clk); #1;
        check_eq("lat_n1_strobe", sram_rd_en, {K{1'b1}});
        check_eq("lat_n1_addr", sram_rd_addr[0], 10'h010);
        @(posedge clk); #1;
        check_eq("lat_n2_valid", valid, 0);
        @(posedge clk); #1;
        check_eq("lat_n3_valid", valid, 1);
        wait_done(dc);
        check_eq("basic_last_cycle", last_xfer_cyc, start_cyc + 10);
        check_eq("basic_done_cycle", dc, start_cyc + 11);

        // Backpressure.
        ready_mode = 1;
        start_burst(10'h020, 11'd16);
        wait_done(dc);
        ready_mode = 0;

        // Address wrap.
        start_burst(10'h3FE, 11'd4);
        wait_done(dc);

        // Zero length.
        s0 = strobes_total;
        start_burst(10'h055, 11'd0);
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 1);
        @(posedge clk); #1;
        check_eq("zero_done_low", done, 0);
        check_eq("zero_busy_low", busy, 0);
        repeat (4) @(negedge clk);
        check_eq("zero_no_strobes", strobes_total, s0);

        // Start pulsed mid-burst is ignored.
        start_burst(10'h100, 11'd12);
        repeat (4) @(posedge clk);
        @(negedge clk);
        base = 10'h200; len = 11'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(dc);

        // Reset mid-burst, then a short burst.
        ready_mode = 1;
        start_burst(10'h050, 11'd20);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        start_burst(10'h123, 11'd3);
        wait_done(dc);

        // Random bursts with random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 5; t++) begin
            start_burst(AW'($urandom), 11'($urandom_range(1, 24)));
            wait_done(dc);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
